// File: rtl/fat_pkg.sv
// rtl/fat_pkg.sv - shared constants, types and helpers for the 64-input fat-tree decoder
package fat_pkg;

  localparam int FAT_GRP_W    = 16;
  localparam int FAT_GRP_N    = 4;
  localparam int FAT_CODE_MAX = 64;

  typedef logic [6:0] fat_code_t;
  typedef logic [1:0] fat_grp_t;

  // Position of a 16-bit group relative to the group holding the code's edge
  typedef enum logic [1:0] {
    GRP_BELOW = 2'd0,
    GRP_EQUAL = 2'd1,
    GRP_ABOVE = 2'd2
  } fat_sel_t;

  // Ones-count of a full thermometer word; used to re-encode the decoder output
  function automatic fat_code_t fat_ones(input logic [FAT_GRP_N*FAT_GRP_W-1:0] w);
    fat_code_t cnt;
    cnt = '0;
    for (int i = 0; i < FAT_GRP_N*FAT_GRP_W; i++) begin
      cnt = cnt + {6'b0, w[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fat16_dec.sv
// rtl/fat16_dec.sv - combinational 16-bit group decoder of the fat-tree decoder
module fat16_dec
  import fat_pkg::*;
(
  input  fat_sel_t              grp_sel,
  input  logic [3:0]            low,
  output logic [FAT_GRP_W-1:0]  grp_word
);

  // Below the edge group: all ones; edge group: low ones; above: all zeros
  always_comb begin
    grp_word = '0;
    case (grp_sel)
      GRP_BELOW: grp_word = '1;
      GRP_EQUAL: grp_word = (16'h1 << low) - 16'h1;
      default:   grp_word = '0;
    endcase
  end

endmodule

// File: rtl/fat64_dec.sv
// rtl/fat64_dec.sv - two-stage pipelined 64-bit fat-tree decoder; optional FAT64_DEC_BUBBLE_CHK_EN
module fat64_dec
  import fat_pkg::*;
#(
  parameter int CODE_W = 7,
  parameter int GRP_N  = FAT_GRP_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CODE_W-1:0]         in_code,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [GRP_N*FAT_GRP_W-1:0] out_therm,
  output logic                      out_ovf,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef FAT64_DEC_BUBBLE_CHK_EN
  ,
  output logic                      err_bubble
`endif
);

  logic                       s1_valid_q, s1_valid_d;
  fat_code_t                  s1_code_q, s1_code_d;
  logic                       s1_ovf_q, s1_ovf_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [GRP_N*FAT_GRP_W-1:0] s2_therm_q, s2_therm_d;
  logic                       s2_ovf_q, s2_ovf_d;

  logic                       s2_load;
  logic                       in_xfer;
  fat_grp_t                   s1_grp;
  logic                       s1_full;
  fat_sel_t                   grp_sel [GRP_N];
  logic [GRP_N*FAT_GRP_W-1:0] dec_word;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;

  assign s1_grp  = s1_code_q[5:4];
  assign s1_full = s1_code_q[6];

  assign out_therm = s2_therm_q;
  assign out_ovf   = s2_ovf_q;
  assign out_valid = s2_valid_q;

  // Stage 1: clamp the code; data only loads on a real transfer so idle X never enters
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_ovf_d   = s1_ovf_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_xfer) begin
      s1_ovf_d  = (in_code > fat_code_t'(FAT_CODE_MAX));
      s1_code_d = s1_ovf_d ? fat_code_t'(FAT_CODE_MAX) : in_code;
    end
  end

  // Classify each group against the edge group; code 64 makes every group full
  always_comb begin
    for (int g = 0; g < GRP_N; g++) begin
      if (s1_full || (fat_grp_t'(g) < s1_grp)) begin
        grp_sel[g] = GRP_BELOW;
      end else if (fat_grp_t'(g) == s1_grp) begin
        grp_sel[g] = GRP_EQUAL;
      end else begin
        grp_sel[g] = GRP_ABOVE;
      end
    end
  end

  for (genvar g = 0; g < GRP_N; g++) begin : g_grp
    fat16_dec u_grp (
      .grp_sel  (grp_sel[g]),
      .low      (s1_code_q[3:0]),
      .grp_word (dec_word[g*FAT_GRP_W +: FAT_GRP_W])
    );
  end

  // Stage 2: take the decoded word when the output slot frees; hold it while stalled
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_therm_d = s2_therm_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_therm_d = dec_word;
        s2_ovf_d   = s1_ovf_q;
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_ovf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_therm_q <= '0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s2_valid_d;
      s2_therm_q <= s2_therm_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

`ifdef FAT64_DEC_BUBBLE_CHK_EN
  fat_code_t s2_code_q, s2_code_d;
  logic      err_q, err_d;
  logic      bubble;

  // Carry the clamped code alongside the stage-2 word so it can be cross-checked
  always_comb begin
    s2_code_d = s2_code_q;
    if (s2_load && s1_valid_q) begin
      s2_code_d = s1_code_q;
    end
  end

  // A valid word whose ones-count differs from its code has a bubble; flag it at once
  always_comb begin
    bubble = s2_valid_q && (fat_ones(s2_therm_q) != s2_code_q);
    err_d  = err_q || bubble;
  end

  assign err_bubble = err_d;

  // Sticky error flag and code shadow, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_code_q <= '0;
      err_q     <= 1'b0;
    end else begin
      s2_code_q <= s2_code_d;
      err_q     <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_fat64_dec.sv
// tb/tb_fat64_dec.sv - directed and scoreboard bench for fat64_dec
module tb_fat64_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  in_code;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_therm;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;
`ifdef FAT64_DEC_BUBBLE_CHK_EN
  logic        err_bubble;
`endif

  fat64_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_therm (out_therm),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FAT64_DEC_BUBBLE_CHK_EN
    ,
    .err_bubble(err_bubble)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  code;
    logic [63:0] therm;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] therm;
    logic        ovf;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          out_count = 0;
  int          base_count;
  int          wait_t;
  vec_t        vecs [14];
  exp_t        exp_q [$];
  exp_t        e;
  logic [63:0] cur_therm;
  logic        cur_ovf;
  logic [6:0]  rc;
  bit          rand_ready_en = 1'b0;
  logic        held_v = 1'b0;
  logic [63:0] held_therm;
  logic        held_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_therm(input logic [6:0] c);
    logic [63:0] m;
    int          n;
    n = (c > 7'd64) ? 64 : int'(c);
    for (int k = 0; k < 64; k++) m[k] = (k < n);
    return m;
  endfunction

  // Present one beat from posedge+1, hold it until accepted, then drop in_valid
  task automatic drive_beat(input logic [6:0] c, input logic [63:0] th, input logic ov);
    int t;
    t = 0;
    in_code   = c;
    cur_therm = th;
    cur_ovf   = ov;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard, stall stability and ready checks on the quiet clock edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
      if (held_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_therm", out_therm, held_therm);
        check("stall_ovf", 64'(out_ovf), 64'(held_ovf));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_therm", out_therm, e.therm);
          check("out_ovf", 64'(out_ovf), 64'(e.ovf));
          out_count++;
        end
      end
      held_v     = out_valid && !out_ready;
      held_therm = out_therm;
      held_ovf   = out_ovf;
      if (in_valid && in_ready) exp_q.push_back('{therm: cur_therm, ovf: cur_ovf});
    end
  end

  // Random downstream backpressure when enabled
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_code   = 7'd10;
    out_ready = 1'b1;
    cur_therm = '0;
    cur_ovf   = 1'b0;

    vecs[0]  = '{7'd0,   64'h0000_0000_0000_0000, 1'b0};
    vecs[1]  = '{7'd1,   64'h0000_0000_0000_0001, 1'b0};
    vecs[2]  = '{7'd15,  64'h0000_0000_0000_7FFF, 1'b0};
    vecs[3]  = '{7'd16,  64'h0000_0000_0000_FFFF, 1'b0};
    vecs[4]  = '{7'd17,  64'h0000_0000_0001_FFFF, 1'b0};
    vecs[5]  = '{7'd31,  64'h0000_0000_7FFF_FFFF, 1'b0};
    vecs[6]  = '{7'd32,  64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[7]  = '{7'd33,  64'h0000_0001_FFFF_FFFF, 1'b0};
    vecs[8]  = '{7'd48,  64'h0000_FFFF_FFFF_FFFF, 1'b0};
    vecs[9]  = '{7'd63,  64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[10] = '{7'd64,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[11] = '{7'd65,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[12] = '{7'd127, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[13] = '{7'd5,   64'h0000_0000_0000_001F, 1'b0};

    // reset held for 3 cycles with in_valid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_therm", out_therm, 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // single beat: two-cycle latency
    in_code   = 7'd17;
    cur_therm = 64'h1FFFF;
    cur_ovf   = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    check("lat_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // hand-computed table, back-to-back, including overflow and recovery
    base_count = out_count;
    for (int i = 0; i < 14; i++) drive_beat(vecs[i].code, vecs[i].therm, vecs[i].ovf);
    drain("table_drain");
    check("table_count", 64'(out_count - base_count), 64'd14);

    // full sweep 0..64 back-to-back
    base_count = out_count;
    for (int c = 0; c <= 64; c++) drive_beat(7'(c), model_therm(7'(c)), 1'b0);
    drain("sweep_drain");
    check("sweep_count", 64'(out_count - base_count), 64'd65);
`ifdef FAT64_DEC_BUBBLE_CHK_EN
    check("bubble_clean", 64'(err_bubble), 64'd0);
`endif

    // random codes under random backpressure
    base_count    = out_count;
    rand_ready_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      rc = 7'($urandom_range(0, 127));
      drive_beat(rc, model_therm(rc), rc > 7'd64);
    end
    drain("rand_drain");
    check("rand_count", 64'(out_count - base_count), 64'd200);
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset with two beats in flight
    out_ready = 1'b0;
    drive_beat(7'd3, 64'h7, 1'b0);
    drive_beat(7'd40, model_therm(7'd40), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    base_count = out_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ghost", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    drive_beat(7'd33, 64'h1_FFFF_FFFF, 1'b0);
    drain("midrst_drain");
    check("midrst_count", 64'(out_count - base_count), 64'd1);

`ifdef FAT64_DEC_BUBBLE_CHK_EN
    // corrupt bit 40 of a code-48 word held in stage 2
    out_ready = 1'b0;
    drive_beat(7'd48, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
    wait_t = 0;
    @(negedge clk);
    while (!out_valid && wait_t < 10) begin
      wait_t++;
      @(negedge clk);
    end
    check("bubble_setup_valid", 64'(out_valid), 64'd1);
    #2;
    force dut.s2_therm_q = 64'h0000_FEFF_FFFF_FFFF;
    #1;
    check("bubble_set", 64'(err_bubble), 64'd1);
    @(posedge clk);
    #1;
    force dut.s2_therm_q = 64'h0000_FFFF_FFFF_FFFF;
    #1;
    release dut.s2_therm_q;
    @(negedge clk);
    check("bubble_sticky", 64'(err_bubble), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drive_beat(7'd5, 64'h1F, 1'b0);
    drain("bubble_drain");
    check("bubble_sticky2", 64'(err_bubble), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("bubble_cleared", 64'(err_bubble), 64'd0);
    @(posedge clk);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
